// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream side of the UART command controller: RX bytes in, key/stream
// outputs to the core, and the single-byte response channel to the TX arbiter.
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_parity_err;
    logic [63:0] key_out;
    logic        mode_out;
    logic        key_en;
    logic [7:0]  data_out;
    logic        data_en;
    logic        stream_end;
    logic [7:0]  ack_data;
    logic        ack_valid;
    logic        ack_ready;
    logic        busy;

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, ack_ready,
        output key_out, mode_out, key_en, data_out, data_en, stream_end,
        output ack_data, ack_valid, busy
    );

    modport master (
        output rx_data, rx_valid, rx_parity_err, ack_ready,
        input  key_out, mode_out, key_en, data_out, data_en, stream_end,
        input  ack_data, ack_valid, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses the UART byte stream into key-load frames, a stream-start command and
// pass-through stream data; answers each command with a one-byte ACK/NAK.
module uart_cmd_ctrl #(
    parameter int unsigned CLK_FREQ   = 200,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter logic [7:0]  CMD_KEY    = 8'hA5,
    parameter logic [7:0]  CMD_STREAM = 8'h5A,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cmd_ctrl_if.slave bus
);

    localparam int unsigned TO_CYCLES = CLK_FREQ * TIMEOUT_US;
    localparam int unsigned TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_MODE,
        S_STREAM,
        S_END
    } state_t;

    state_t            r_state;
    logic [63:0]       r_shadow;
    logic [2:0]        r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_key_loaded;
    logic [63:0]       r_key_out;
    logic              r_mode_out;
    logic              r_key_en;
    logic [7:0]        r_data_out;
    logic              r_data_en;
    logic              r_stream_end;
    logic [7:0]        r_ack_data;
    logic              r_ack_valid;
    logic              r_busy;

    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_queue;
    logic [7:0]        w_resp;
    logic              w_shift;
    logic              w_commit;
    logic              w_data_strobe;
    logic              w_end_set;
    logic [2:0]        w_cnt_nxt;
    logic [TO_W-1:0]   w_to_nxt;

    assign w_accept = bus.rx_valid && !bus.rx_parity_err;

    // Next-state and per-cycle actions; parity error outranks the byte it rides on
    always_comb begin
        w_state_nxt   = r_state;
        w_queue       = 1'b0;
        w_resp        = NAK_BYTE;
        w_shift       = 1'b0;
        w_commit      = 1'b0;
        w_data_strobe = 1'b0;
        w_end_set     = 1'b0;
        w_cnt_nxt     = r_byte_cnt;
        w_to_nxt      = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_parity_err) begin
                    w_queue = 1'b1;
                end else if (w_accept) begin
                    if (bus.rx_data == CMD_KEY) begin
                        w_state_nxt = S_KEY;
                        w_cnt_nxt   = 3'd0;
                    end else if (bus.rx_data == CMD_STREAM && r_key_loaded) begin
                        w_state_nxt = S_STREAM;
                        w_queue     = 1'b1;
                        w_resp      = ACK_BYTE;
                    end else begin
                        w_queue = 1'b1;
                    end
                end
            end

            S_KEY: begin
                if (bus.rx_parity_err) begin
                    w_queue     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_byte_cnt + 3'd1;
                    if (r_byte_cnt == 3'd7) begin
                        w_state_nxt = S_MODE;
                    end
                end else if (r_to_cnt == TO_MAX) begin
                    w_queue     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end

            S_MODE: begin
                if (bus.rx_parity_err) begin
                    w_queue     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    w_commit    = 1'b1;
                    w_queue     = 1'b1;
                    w_resp      = ACK_BYTE;
                    w_state_nxt = S_IDLE;
                end else if (r_to_cnt == TO_MAX) begin
                    w_queue     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end

            S_STREAM: begin
                if (bus.rx_parity_err) begin
                    w_end_set   = 1'b1;
                    w_state_nxt = S_END;
                end else if (w_accept) begin
                    w_data_strobe = 1'b1;
                end
            end

            S_END: begin
                w_state_nxt = S_END;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shadow     <= '0;
            r_byte_cnt   <= '0;
            r_to_cnt     <= '0;
            r_key_loaded <= 1'b0;
            r_key_out    <= '0;
            r_mode_out   <= 1'b0;
            r_key_en     <= 1'b0;
            r_data_out   <= '0;
            r_data_en    <= 1'b0;
            r_stream_end <= 1'b0;
            r_ack_data   <= '0;
            r_ack_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_cnt_nxt;
            r_to_cnt   <= w_to_nxt;
            r_key_en   <= w_commit;
            r_data_en  <= w_data_strobe;
            r_busy     <= (w_state_nxt == S_KEY) || (w_state_nxt == S_MODE);

            if (w_shift) begin
                r_shadow <= {r_shadow[55:0], bus.rx_data};
            end
            if (w_commit) begin
                r_key_out    <= r_shadow;
                r_mode_out   <= bus.rx_data[0];
                r_key_loaded <= 1'b1;
            end
            if (w_data_strobe) begin
                r_data_out <= bus.rx_data;
            end
            if (w_end_set) begin
                r_stream_end <= 1'b1;
            end

            // A new response wins over a same-cycle handshake of the old one
            if (w_queue) begin
                r_ack_valid <= 1'b1;
                r_ack_data  <= w_resp;
            end else if (r_ack_valid && bus.ack_ready) begin
                r_ack_valid <= 1'b0;
            end
        end
    end

    assign bus.key_out    = r_key_out;
    assign bus.mode_out   = r_mode_out;
    assign bus.key_en     = r_key_en;
    assign bus.data_out   = r_data_out;
    assign bus.data_en    = r_data_en;
    assign bus.stream_end = r_stream_end;
    assign bus.ack_data   = r_ack_data;
    assign bus.ack_valid  = r_ack_valid;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized self-checking bench for uart_cmd_ctrl against a small
// command-level model (loaded key, mode, expected responses).
module tb_uart_cmd_ctrl;

    localparam logic [7:0] CMD_KEY    = 8'hA5;
    localparam logic [7:0] CMD_STREAM = 8'h5A;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam int TO_CYCLES = 200;

    logic clk;
    logic rst_n;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .CLK_FREQ   (200),
        .TIMEOUT_US (1),
        .CMD_KEY    (CMD_KEY),
        .CMD_STREAM (CMD_STREAM),
        .ACK_BYTE   (ACK_BYTE),
        .NAK_BYTE   (NAK_BYTE)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int key_en_cnt  = 0;
    int data_en_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] q_ack[$];

    // Command-level model of what the core should currently hold
    logic [63:0] m_key    = '0;
    logic        m_mode   = 1'b0;
    logic        m_loaded = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe pulses and completed response handshakes mid-cycle
    always @(negedge clk) begin
        if (bus.key_en) key_en_cnt++;
        if (bus.data_en) data_en_cnt++;
        if (bus.key_en && bus.data_en) overlap_cnt++;
        if (bus.ack_valid && bus.ack_ready) q_ack.push_back(bus.ack_data);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr);
        bus.rx_data       = b;
        bus.rx_valid      = 1'b1;
        bus.rx_parity_err = perr;
        @(posedge clk);
        #1;
        bus.rx_valid      = 1'b0;
        bus.rx_parity_err = 1'b0;
        bus.rx_data       = 8'($urandom);
    endtask

    task automatic do_reset();
        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.rx_parity_err = 1'b0;
        bus.ack_ready     = 1'b1;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        m_key    = '0;
        m_mode   = 1'b0;
        m_loaded = 1'b0;
        q_ack.delete();
    endtask

    task automatic wait_ack(input logic [7:0] exp, input string name);
        int t;
        logic [7:0] got;
        t = 0;
        while (q_ack.size() == 0 && t < 10) begin
            idle(1);
            t++;
        end
        n_tests++;
        if (q_ack.size() == 0) begin
            $display("FAIL %s: no response within 10 cycles, required %h", name, exp);
            n_fail++;
        end else begin
            got = q_ack.pop_front();
            if (got !== exp) begin
                $display("FAIL %s: response %h, required %h", name, got, exp);
                n_fail++;
            end
        end
    endtask

    function automatic logic [7:0] rand_non_cmd();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == CMD_KEY || b == CMD_STREAM) b = 8'($urandom);
        return b;
    endfunction

    task automatic send_key_bytes(input logic [63:0] k);
        send_byte(CMD_KEY, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 2));
            send_byte(k[63 - 8*i -: 8], 1'b0);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.key_out, bus.mode_out, bus.key_en, bus.data_out, bus.data_en,
             bus.stream_end, bus.ack_data, bus.ack_valid, bus.busy} !== 86'd0) begin
            $display("FAIL reset_outputs: key=%h mode=%b ken=%b data=%h den=%b end=%b ack=%h av=%b busy=%b, required all 0",
                     bus.key_out, bus.mode_out, bus.key_en, bus.data_out, bus.data_en,
                     bus.stream_end, bus.ack_data, bus.ack_valid, bus.busy);
            n_fail++;
        end
    endtask

    task automatic test_key_load(input logic [63:0] k, input logic m);
        int kc0;
        logic [7:0] mb;
        kc0 = key_en_cnt;
        q_ack.delete();
        send_key_bytes(k);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL key_busy: busy=%b before mode byte, required 1", bus.busy);
            n_fail++;
        end
        mb = 8'($urandom);
        mb[0] = m;
        idle($urandom_range(0, 2));
        send_byte(mb, 1'b0);
        n_tests++;
        if (bus.key_en !== 1'b1 || bus.key_out !== k || bus.mode_out !== m || bus.busy !== 1'b0) begin
            $display("FAIL key_commit: ken=%b key=%h mode=%b busy=%b, required 1 %h %b 0",
                     bus.key_en, bus.key_out, bus.mode_out, bus.busy, k, m);
            n_fail++;
        end
        m_key    = k;
        m_mode   = m;
        m_loaded = 1'b1;
        wait_ack(ACK_BYTE, "key_ack");
        idle(1);
        n_tests++;
        if (key_en_cnt - kc0 != 1 || bus.key_en !== 1'b0) begin
            $display("FAIL key_en_pulse: %0d pulses now ken=%b, required 1 pulse then 0",
                     key_en_cnt - kc0, bus.key_en);
            n_fail++;
        end
    endtask

    task automatic test_nak_no_key();
        int dc0;
        logic [7:0] b;
        dc0 = data_en_cnt;
        q_ack.delete();
        send_byte(CMD_STREAM, 1'b0);
        wait_ack(NAK_BYTE, "stream_no_key");
        send_byte(8'h33, 1'b0);
        wait_ack(NAK_BYTE, "idle_byte_33");
        for (int i = 0; i < 4; i++) begin
            b = rand_non_cmd();
            send_byte(b, $urandom_range(0, 1) == 1);
            wait_ack(NAK_BYTE, "idle_random");
        end
        idle(3);
        n_tests++;
        if (data_en_cnt != dc0 || bus.busy !== 1'b0) begin
            $display("FAIL nak_idle_state: data_en pulses=%0d busy=%b, required 0 0",
                     data_en_cnt - dc0, bus.busy);
            n_fail++;
        end
    endtask

    task automatic test_stream();
        logic [7:0] bytes[$];
        int dc0;
        bytes = '{8'h10, 8'h20, 8'h30};
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
        q_ack.delete();
        send_byte(CMD_STREAM, 1'b0);
        wait_ack(ACK_BYTE, "stream_ack");
        dc0 = data_en_cnt;
        foreach (bytes[i]) begin
            send_byte(bytes[i], 1'b0);
            n_tests++;
            if (bus.data_en !== 1'b1 || bus.data_out !== bytes[i]) begin
                $display("FAIL stream_data[%0d]: den=%b data=%h, required 1 %h",
                         i, bus.data_en, bus.data_out, bytes[i]);
                n_fail++;
            end
            if (i < 3) begin
                idle(1);
                n_tests++;
                if (bus.data_en !== 1'b0) begin
                    $display("FAIL stream_gap[%0d]: den=%b, required 0", i, bus.data_en);
                    n_fail++;
                end
            end
        end
        send_byte(8'($urandom), 1'b1);
        n_tests++;
        if (bus.stream_end !== 1'b1 || bus.data_en !== 1'b0) begin
            $display("FAIL stream_end_set: end=%b den=%b, required 1 0", bus.stream_end, bus.data_en);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            send_byte((i == 2) ? CMD_KEY : 8'($urandom), $urandom_range(0, 1) == 1);
        end
        idle(3);
        n_tests++;
        if (data_en_cnt - dc0 != bytes.size() || q_ack.size() != 0 || bus.stream_end !== 1'b1) begin
            $display("FAIL stream_terminal: pulses=%0d acks=%0d end=%b, required %0d 0 1",
                     data_en_cnt - dc0, q_ack.size(), bus.stream_end, bytes.size());
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        int kc0;
        kc0 = key_en_cnt;
        q_ack.delete();
        send_byte(CMD_KEY, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        idle(TO_CYCLES - 5);
        n_tests++;
        if (q_ack.size() != 0 || bus.ack_valid !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL timeout_early: acks=%0d av=%b busy=%b, required 0 0 1",
                     q_ack.size(), bus.ack_valid, bus.busy);
            n_fail++;
        end
        wait_ack(NAK_BYTE, "timeout_nak");
        n_tests++;
        if (bus.key_out !== m_key || bus.mode_out !== m_mode || key_en_cnt != kc0 || bus.busy !== 1'b0) begin
            $display("FAIL timeout_keep: key=%h mode=%b pulses=%0d busy=%b, required %h %b 0 0",
                     bus.key_out, bus.mode_out, key_en_cnt - kc0, bus.busy, m_key, m_mode);
            n_fail++;
        end
    endtask

    task automatic test_parity_abort(input int pos);
        int kc0;
        kc0 = key_en_cnt;
        q_ack.delete();
        send_byte(CMD_KEY, 1'b0);
        for (int i = 0; i < pos; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        wait_ack(NAK_BYTE, "parity_abort");
        n_tests++;
        if (bus.key_out !== m_key || bus.mode_out !== m_mode || key_en_cnt != kc0 || bus.busy !== 1'b0) begin
            $display("FAIL parity_keep(pos %0d): key=%h mode=%b pulses=%0d busy=%b, required %h %b 0 0",
                     pos, bus.key_out, bus.mode_out, key_en_cnt - kc0, bus.busy, m_key, m_mode);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] k;
        logic [7:0]  got0, got1;
        q_ack.delete();
        bus.ack_ready = 1'b0;
        send_byte(8'h33, 1'b0);
        n_tests++;
        if (bus.ack_valid !== 1'b1 || bus.ack_data !== NAK_BYTE) begin
            $display("FAIL hold_nak: av=%b ack=%h, required 1 %h", bus.ack_valid, bus.ack_data, NAK_BYTE);
            n_fail++;
        end
        k = {32'($urandom), 32'($urandom)};
        send_key_bytes(k);
        send_byte(8'h01, 1'b0);
        m_key = k; m_mode = 1'b1; m_loaded = 1'b1;
        idle(2);
        n_tests++;
        if (bus.ack_valid !== 1'b1 || bus.ack_data !== ACK_BYTE || q_ack.size() != 0) begin
            $display("FAIL hold_overwrite: av=%b ack=%h acks=%0d, required 1 %h 0",
                     bus.ack_valid, bus.ack_data, q_ack.size(), ACK_BYTE);
            n_fail++;
        end
        bus.ack_ready = 1'b1;
        idle(1);
        n_tests++;
        if (bus.ack_valid !== 1'b0 || q_ack.size() != 1) begin
            $display("FAIL hold_release: av=%b acks=%0d, required 0 1", bus.ack_valid, q_ack.size());
            n_fail++;
        end
        wait_ack(ACK_BYTE, "hold_release_byte");

        // Queue a new response in the same cycle the pending one is accepted
        bus.ack_ready = 1'b0;
        send_byte(rand_non_cmd(), 1'b0);
        k = {32'($urandom), 32'($urandom)};
        send_key_bytes(k);
        bus.ack_ready = 1'b1;
        send_byte(8'h00, 1'b0);
        m_key = k; m_mode = 1'b0;
        n_tests++;
        if (bus.ack_valid !== 1'b1 || bus.ack_data !== ACK_BYTE || bus.key_out !== k) begin
            $display("FAIL queue_with_handshake: av=%b ack=%h key=%h, required 1 %h %h",
                     bus.ack_valid, bus.ack_data, bus.key_out, ACK_BYTE, k);
            n_fail++;
        end
        idle(1);
        got0 = (q_ack.size() > 0) ? q_ack[0] : 8'hxx;
        got1 = (q_ack.size() > 1) ? q_ack[1] : 8'hxx;
        n_tests++;
        if (q_ack.size() != 2 || got0 !== NAK_BYTE || got1 !== ACK_BYTE || bus.ack_valid !== 1'b0) begin
            $display("FAIL queue_with_handshake_seq: n=%0d first=%h second=%h av=%b, required 2 %h %h 0",
                     q_ack.size(), got0, got1, bus.ack_valid, NAK_BYTE, ACK_BYTE);
            n_fail++;
        end
        q_ack.delete();
    endtask

    task automatic test_random_traffic();
        int kind;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                test_key_load({32'($urandom), 32'($urandom)}, $urandom_range(0, 1) == 1);
            end else if (kind == 1) begin
                q_ack.delete();
                send_byte(rand_non_cmd(), 1'b0);
                wait_ack(NAK_BYTE, "random_idle_nak");
            end else begin
                test_parity_abort($urandom_range(0, 8));
            end
        end
    endtask

    task automatic test_async_reset();
        int dc0;
        q_ack.delete();
        send_byte(CMD_STREAM, 1'b0);
        wait_ack(ACK_BYTE, "pre_reset_stream_ack");
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.key_out, bus.mode_out, bus.key_en, bus.data_out, bus.data_en,
             bus.stream_end, bus.ack_data, bus.ack_valid, bus.busy} !== 86'd0) begin
            $display("FAIL async_reset: key=%h mode=%b den=%b data=%h end=%b av=%b, required all 0",
                     bus.key_out, bus.mode_out, bus.data_en, bus.data_out, bus.stream_end, bus.ack_valid);
            n_fail++;
        end
        idle(2);
        rst_n = 1'b1;
        m_key = '0; m_mode = 1'b0; m_loaded = 1'b0;
        idle(1);
        q_ack.delete();
        dc0 = data_en_cnt;
        send_byte(CMD_STREAM, 1'b0);
        wait_ack(NAK_BYTE, "post_reset_stream_nak");
        send_byte(8'($urandom), 1'b0);
        idle(2);
        n_tests++;
        if (data_en_cnt != dc0 || bus.stream_end !== 1'b0 || bus.key_out !== m_key) begin
            $display("FAIL post_reset_idle: pulses=%0d end=%b key=%h, required 0 0 %h",
                     data_en_cnt - dc0, bus.stream_end, bus.key_out, m_key);
            n_fail++;
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_nak_no_key();
        test_key_load(64'h0123456789ABCDEF, 1'b1);
        test_stream();

        do_reset();
        test_reset();
        test_key_load(64'h0123456789ABCDEF, 1'b1);
        test_timeout();
        test_key_load({32'($urandom), 32'($urandom)}, 1'b0);
        test_parity_abort(2);
        test_parity_abort(8);
        test_back_to_back();
        test_random_traffic();
        if (!m_loaded) test_key_load({32'($urandom), 32'($urandom)}, 1'b1);
        test_async_reset();

        n_tests++;
        if (overlap_cnt != 0) begin
            $display("FAIL key_data_overlap: %0d cycles with key_en and data_en, required 0", overlap_cnt);
            n_fail++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command/configuration controller between `uart_rx` and the bhargava core.
- Parses the received byte stream into three kinds of traffic: key-load frames (8 key bytes + 1 mode byte), a stream-start command, and pass-through MPEG data.
- Drives the core's `key_in`/`mode_in`/`key_en`, `mpeg_in`/`mpeg_in_en` and `stream_end` inputs.
- Returns single-byte ACK/NAK responses to the TX-side arbiter.

Parameters:
- CLK_FREQ, 200, clock frequency in MHz.
- TIMEOUT_US, 1000, maximum inter-byte gap inside a key frame, in µs; timeout cycles = CLK_FREQ*TIMEOUT_US.
- CMD_KEY, 8'hA5, command byte that opens a key-load frame.
- CMD_STREAM, 8'h5A, command byte that starts the data stream.
- ACK_BYTE, 8'h06, positive response byte.
- NAK_BYTE, 8'h15, negative response byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from uart_rx
- rx_valid  in  1  1-cycle strobe, rx_data valid
- rx_parity_err  in  1  1-cycle strobe, parity error on the current byte
- key_out  out  64  committed DES key, first received byte in [63:56]
- mode_out  out  1  committed mode (bit 0 of the mode byte)
- key_en  out  1  1-cycle pulse: key_out/mode_out newly committed
- data_out  out  8  stream byte to core
- data_en  out  1  1-cycle strobe, data_out valid
- stream_end  out  1  sticky end-of-stream flag
- ack_data  out  8  response byte
- ack_valid  out  1  response pending
- ack_ready  in  1  response consumer ready
- busy  out  1  high in S_KEY or S_MODE

Behaviour:
- Reset (async assert, synchronous release handled upstream): state = S_IDLE. All outputs 0, including key_out, mode_out, stream_end and ack_valid. key_loaded flag = 0. Byte counter = 0. Timeout counter = 0.
- Byte acceptance: a byte is accepted when rx_valid=1 and rx_parity_err=0. If rx_parity_err=1 in a cycle, that cycle's byte is discarded even if rx_valid=1.
- S_IDLE, on an accepted byte:
  - CMD_KEY → S_KEY; byte counter = 0; timeout counter cleared.
  - CMD_STREAM with key_loaded=1 → S_STREAM and queue ACK_BYTE.
  - CMD_STREAM with key_loaded=0 → queue NAK_BYTE; stay in S_IDLE.
  - Any other byte → queue NAK_BYTE; stay in S_IDLE.
- S_IDLE, on a parity error: queue NAK_BYTE; stay in S_IDLE.
- S_KEY:
  - Each accepted byte is written to a 64-bit shadow register, MSB byte first, and increments the byte counter.
  - After the 8th byte → S_MODE.
  - Timeout counter clears on every accepted byte.
- S_MODE, on an accepted byte, at the next edge:
  - key_out ← shadow; mode_out ← rx_data[0].
  - key_en pulses high for exactly 1 cycle; key_loaded ← 1.
  - Queue ACK_BYTE; → S_IDLE.
- Abort in S_KEY or S_MODE: parity error, or timeout counter reaching CLK_FREQ*TIMEOUT_US-1.
  - Queue NAK_BYTE; → S_IDLE.
  - Shadow contents are discarded; key_out, mode_out and key_loaded are unchanged.
- S_STREAM:
  - Each accepted byte → data_out = rx_data and data_en = 1 on the following cycle (1-cycle latency, no back-pressure).
  - Parity error → stream_end ← 1; → S_END.
- S_END: terminal. All bytes and errors are ignored and no ACK/NAK is generated; only rst_n exits.
- Timeout counter runs only in S_KEY and S_MODE; it saturates and does not wrap; width = $clog2(CLK_FREQ*TIMEOUT_US).
- Response channel:
  - Queuing a response sets ack_valid=1 and ack_data on the next edge.
  - The response is held until a cycle with ack_valid && ack_ready, after which ack_valid=0 on the next edge.
  - A new response queued while one is pending overwrites ack_data; ack_valid stays 1.
  - A queue and an ack_ready handshake in the same cycle leave ack_valid=1 with the new byte.
- key_en and data_en are never high in the same cycle, by construction.

Test Plan:
- Reset, then A5, 01 23 45 67 89 AB CD EF, 01 → key_out=64'h0123456789ABCDEF, mode_out=1, a single 1-cycle key_en pulse, ack_data=06, busy low after the mode byte.
- After a key load, send 5A, then 10,20,30 → ACK 06; data_en pulses three times with data_out 10,20,30, each one cycle after its rx_valid; then a parity error → stream_end=1, and later bytes produce no data_en.
- From reset, send 5A with no key loaded → NAK 15, state stays idle, data_en never asserts. Also send byte 33 in idle → NAK 15.
- After a committed key 0123456789ABCDEF, send A5 + 4 bytes, then idle for CLK_FREQ*TIMEOUT_US cycles (use TIMEOUT_US=1 for speed) → NAK 15; key_out unchanged, no key_en. A following full key frame succeeds.
- Parity error on the 3rd key byte → NAK 15 and return to idle. Also hold ack_ready=0 across two queued responses (NAK then ACK) → ack_valid stays high, ack_data=06, cleared one cycle after ack_ready=1.
- Assert rst_n=0 mid-stream, asynchronously between clock edges → all outputs 0 immediately; stream_end=0, key_loaded=0, and a subsequent 5A gets NAK 15.
